// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan scheduler.
//   state_t   : job sequencer states
//   FLUSH_LEN : number of zero bits pushed to clear the detector window
//   cnt_width : width needed to hold a hit count for a DATA_W-bit word
package pattern_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int FLUSH_LEN = 2;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/pattern_scan_sched_rr_arbiter.sv
// Round-robin arbiter for the pattern scan scheduler.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_req      : per-requester request bits
//   i_advance  : the current grant is being taken; move pointer past it
//   o_grant    : one-hot grant (combinational), first set req at/after ptr
//   o_id       : encoded index of o_grant
//   o_ptr      : current priority pointer (debug visibility)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id,
  output logic [ID_W-1:0]    o_ptr
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // Scan from the pointer upward, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_id == ID_W'(NUM_REQ - 1)) ? '0 : o_id + ID_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/pattern_scan_sched.sv
// Time-shares one serial 3-bit-window pattern detector among NUM_REQ
// requesters. Each job captures a word, flushes the detector window with
// FLUSH_LEN zeros, shifts the word LSB-first, counts detector hits and
// reports the count with a one-cycle done pulse tagged by requester id.
//
// Request handshake: a requester raises req[i] with req_data slice i stable
// and holds both until it sees gnt[i] (a one-cycle pulse); the word is taken
// in that gnt cycle and req[i] may then drop or re-arm with a new word.
// A req dropped before its gnt is simply forgotten.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req/req_data  : per-requester request and DATA_W-bit word
//   gnt           : one-hot grant pulse
//   done/done_id/done_count : job completion pulse, requester id, hit count
//   det_serial/det_enable   : drive to the detector
//   det_hit       : detector output (registered inside the detector)
//   o_dbg_state   : sequencer state
//   o_dbg_ptr     : round-robin pointer
module pattern_scan_sched
  import pattern_scan_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = cnt_width(DATA_W),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          done_count,
  output logic                      det_serial,
  output logic                      det_enable,
  input  logic                      det_hit,
  output state_t                    o_dbg_state,
  output logic [ID_W-1:0]           o_dbg_ptr
);

  localparam int BIT_W = $clog2(DATA_W);

  state_t             r_state, w_state_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [DATA_W-1:0]  r_word;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_hits, w_hits_nxt;
  logic               w_issue, w_sample;

  logic [NUM_REQ-1:0] r_gnt;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic [CNT_W-1:0]   r_done_count;
  logic               r_det_serial, r_det_enable;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [ID_W-1:0]    w_arb_id, w_arb_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .i_advance (w_issue),
    .o_grant   (w_arb_gnt),
    .o_id      (w_arb_id),
    .o_ptr     (w_arb_ptr)
  );

  // Grants are issued from IDLE (when no grant is in flight) and from DONE,
  // so a held request is granted in the cycle right after done. The IDLE
  // cycle that shows gnt then hands over to FLUSH.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|r_gnt) begin
          w_state_nxt = FLUSH;
          w_bit_nxt   = '0;
        end else if (|req) begin
          w_issue = 1'b1;
        end
      end
      FLUSH: begin
        if (r_bit == BIT_W'(FLUSH_LEN - 1)) begin
          w_state_nxt = SHIFT;
          w_bit_nxt   = '0;
        end else begin
          w_bit_nxt = r_bit + BIT_W'(1);
        end
      end
      SHIFT: begin
        if (r_bit == BIT_W'(DATA_W - 1)) begin
          w_state_nxt = DRAIN;
          w_bit_nxt   = '0;
        end else begin
          w_bit_nxt = r_bit + BIT_W'(1);
        end
      end
      DRAIN: w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = IDLE;
        if (|req) w_issue = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // det_hit reflects the bit shown one cycle earlier, so the first SHIFT
  // cycle sees the tail of the flush and is skipped; DRAIN sees the last bit.
  always_comb begin
    w_sample   = ((r_state == SHIFT) && (r_bit != '0)) || (r_state == DRAIN);
    w_hits_nxt = r_hits;
    if (w_issue)                  w_hits_nxt = '0;
    else if (w_sample && det_hit) w_hits_nxt = r_hits + CNT_W'(1);
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit        <= '0;
      r_word       <= '0;
      r_id         <= '0;
      r_hits       <= '0;
      r_gnt        <= '0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_done_count <= '0;
      r_det_serial <= 1'b0;
      r_det_enable <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_hits  <= w_hits_nxt;
      r_gnt   <= w_issue ? w_arb_gnt : '0;
      if (w_issue) begin
        r_word <= req_data[w_arb_id*DATA_W +: DATA_W];
        r_id   <= w_arb_id;
      end
      r_done <= (w_state_nxt == DONE);
      if (w_state_nxt == DONE) begin
        r_done_id    <= r_id;
        r_done_count <= w_hits_nxt;
      end
      r_det_enable <= (w_state_nxt == FLUSH) || (w_state_nxt == SHIFT);
      r_det_serial <= (w_state_nxt == SHIFT) ? r_word[w_bit_nxt] : 1'b0;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign done_id     = r_done_id;
  assign done_count  = r_done_count;
  assign det_serial  = r_det_serial;
  assign det_enable  = r_det_enable;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = w_arb_ptr;

endmodule

// File: doc/pattern_scan_sched.md
Name: pattern_scan_sched

Overview:
- Shares one serial 3-bit-window pattern detector among NUM_REQ requesters, granted round-robin.
- Per job:
  - captures a DATA_W-bit word;
  - flushes the detector window;
  - shifts the word in LSB-first with the detector enabled;
  - counts detector hits;
  - returns the hit count with a one-cycle done pulse tagged with the requester id.
- Sits between requester logic and a single detector instance. The detector asserts its hit output, registered, one cycle after a bit arrives whose 3-bit window {newest, mid, oldest} is nonzero with even parity (011, 101, 110).

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_W, 16, bits per job word (≥3).
- CNT_W, $clog2(DATA_W+1), width of the hit count.
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until the matching gnt.
- req_data  in  NUM_REQ*DATA_W  per-requester word; slice i belongs to requester i; stable while req[i] is high.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; word captured that cycle.
- done  out  1  one-cycle pulse; job complete.
- done_id  out  ID_W  requester served; valid with done.
- done_count  out  CNT_W  hits for that job; valid with done.
- det_serial  out  1  serial bit to the detector.
- det_enable  out  1  detector enable.
- det_hit  in  1  detector pattern_detected output.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt=0, done=0, done_id=0, done_count=0, det_serial=0, det_enable=0.
  - rr pointer=0, hit counter=0, bit counter=0.
  - Reset mid-job aborts the job silently: no done; the requester is not re-granted automatically. Requester must keep or re-raise req.
- FSM states: IDLE, FLUSH, SHIFT, DRAIN, DONE. All outputs are registered.
- IDLE:
  - If any req is set, grant the first set bit at or after ptr, wrapping modulo NUM_REQ.
  - gnt[k]=1 for that cycle; capture req_data slice k and id k; ptr<=k+1 (wraps to 0).
  - Clear the hit counter; go to FLUSH. No req → stay.
- FLUSH: 2 cycles, det_enable=1, det_serial=0. det_hit is ignored in these cycles and the cycle after.
- SHIFT:
  - DATA_W cycles, det_enable=1, det_serial=word[i], i=0..DATA_W-1 (LSB first).
  - Bit 0 window is {b0,0,0}; bit 1 window is {b1,b0,0}.
- Hit sampling: sample det_hit in the cycle after each data bit (SHIFT cycles 2..DATA_W, then DRAIN); increment the counter when det_hit=1.
- DRAIN: 1 cycle, det_enable=0, det_serial=0; samples the hit for the last bit.
- DONE: 1 cycle with done=1, done_id, done_count=final count; then IDLE.
- Latency: gnt in cycle T → done in cycle T+DATA_W+4. Next grant no earlier than T+DATA_W+5.
- det_enable is 0 in IDLE, DRAIN and DONE.
- Count never exceeds DATA_W-1; no saturation needed.
- Requests arriving during a job wait; req deasserted before grant is dropped without error.
- done_id and done_count hold their values until the next done; done itself is a strict pulse.

Decomposition:
- Package pattern_scan_pkg: state enum (IDLE, FLUSH, SHIFT, DRAIN, DONE), FLUSH_LEN=2 localparam, and a function returning the count width from DATA_W.
- One natural sub-module: rr_arbiter (NUM_REQ). Inputs: req, advance strobe. Outputs: one-hot grant, encoded id, internal pointer.

Test Plan:
- Only req[0], data 16'hFFFF → gnt[0] at T; done at T+20; done_id=0; done_count=1 (hit only on bit 1).
- Only req[2], data 16'h5555 → done_id=2, done_count=7; data 16'hAAAA → 7; data 16'h0000 → 0; data 16'h0003 → 2.
- req=4'b1111 held with distinct words → gnt order 0,1,2,3,0, spaced 21 cycles apart. Each done_id and done_count matches its word.
- Two back-to-back jobs, first data 16'h8000, second 16'h0001 → second count=0. This proves the flush isolates jobs, and no hit is counted in flush cycles.
- rst pulsed during SHIFT bit 7 → outputs 0 asynchronously, no done. After release, held req[1] is granted with ptr=0 and completes with the correct count.
- det_hit forced to 1 during IDLE, FLUSH and DONE → those cycles do not contribute to done_count.
